store_merge_unit: RTL
=====================

# store_merge_unit

Store-path counterpart to the write-back data mux: takes a register value (rt) and an effective address from the multicycle datapath and produces the full 32-bit word written to data memory for sw, sh and sb. Byte and halfword stores are performed as a read-modify-write on the single-port data memory: read the containing word, merge the sub-word lane, then write the word back. The control FSM starts the block with a one-cycle `Start` pulse and stalls on `Busy` until `Done`.

## Interface
- `RD_LAT`, default 1: cycles from word address presented on `MemAddr` to valid `MemDataOut`; legal range 1..3.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `Start` in 1: request pulse; sampled only while the FSM is in IDLE.
- `StoreType` in 2: 00 = sw, 01 = sh, 10 = sb, 11 = reserved (treated as sw).
- `Addr` in 32: effective byte address (ALUOut).
- `RegData` in 32: store source (rt value).
- `MemDataOut` in 32: read data from data memory.
- `MemAddr` out 32: word-aligned memory address, {Addr[31:2], 2'b00}.
- `MemWR` out 1: memory write enable; high for exactly one cycle per completed store.
- `MemDataIn` out 32: word written to memory.
- `Busy` out 1: high from the cycle after `Start` is accepted until the write cycle ends.
- `Done` out 1: one-cycle completion pulse.
- `Misalign` out 1: one-cycle misaligned-access pulse. Tied 0 unless the macro under Configuration is defined.

## Operation
- FSM states: IDLE, READ, WRITE.
- All outputs are driven from registers. There is no combinational path from any input to any output.
- **IDLE**
  - If `Start`=1, capture `Addr`, `RegData` and `StoreType`.
  - sw or reserved type: go to WRITE.
  - sh or sb: go to READ.
- **READ**
  - `MemAddr` = word address, `MemWR`=0.
  - A down-counter runs for `RD_LAT` cycles.
  - At the edge ending the last READ cycle, `MemDataOut` is merged into the data register; go to WRITE.
- **Merge rules** (little-endian; byte lane k = bits [8k+7:8k]):
  - sb: lane Addr[1:0] is replaced with RegData[7:0]; the other three lanes keep the read data.
  - sh: Addr[1]=0 replaces bits [15:0] with RegData[15:0]; Addr[1]=1 replaces bits [31:16] with RegData[15:0].
  - sw: `MemDataIn` = RegData unchanged; no read is issued.
- **WRITE**
  - `MemWR`=1 and `MemDataIn` = merged word for one cycle; go to IDLE.
  - `Done`=1 in the following cycle.
- **Start handling**
  - `Start` while `Busy`=1 is ignored and is not queued.
  - `Start` in the same cycle as `Done` is accepted, giving back-to-back operation.
- **Reset values**
  - `MemAddr`=0, `MemWR`=0, `MemDataIn`=0, `Busy`=0, `Done`=0, `Misalign`=0; state = IDLE; counter = 0.
- **Reset mid-operation**
  - All outputs clear immediately (asynchronous).
  - An in-progress RMW is abandoned and no partial write occurs.
  - If reset is asserted during WRITE, `MemWR` drops the same instant.

## Timing
- Start is accepted at edge T.
- sw: WRITE in cycle T+1, `Done` in T+2, `Busy` high in T+1 only.
- sh/sb: READ in T+1..T+RD_LAT, WRITE in T+RD_LAT+1, `Done` in T+RD_LAT+2.
- `MemAddr` is held stable from the first READ cycle through WRITE.
- Captured `Addr`/`RegData` are held internally; inputs may change after the accept edge.

## Configuration
- **Macro `STORE_ALIGN_CHECK_EN`**
- **Defined:**
  - An sh with Addr[0]=1, or an sw with Addr[1:0]≠0, is rejected in IDLE.
  - The next cycle (T+1) has `Misalign`=1 and `Done`=1; there is no READ, no `MemWR`, and `Busy` stays 0.
  - sb is never misaligned.
- **Not defined:**
  - `Misalign` is constant 0.
  - sh ignores Addr[0] (lane chosen by Addr[1]); sw ignores Addr[1:0].

## Test plan
All scenarios use RD_LAT=1 unless noted.
- **sw:** Start, Addr=0x00000106, RegData=0xDEADBEEF → T+1: MemWR=1, MemAddr=0x00000104, MemDataIn=0xDEADBEEF; T+2: Done=1.
- **sb:** Addr=0x103, RegData=0x000000AB, memory[0x100]=0x11223344 → READ at 0x100; write 0xAB223344 at T+2; Done at T+3. Repeat with lanes 0..2 → 0x112233AB, 0x1122AB44, 0x11AB3344.
- **sh:** Addr=0x102, RegData=0x0000CAFE, memory 0x11223344 → write 0xCAFE3344. With Addr=0x100 → 0x1122CAFE. With RD_LAT=3 → Done at T+5.
- **Start rules:** Start pulses during Busy produce exactly one MemWR. A Start coincident with Done is accepted, and its write lands at the expected cycle.
- **Reset:** reset asserted in the READ cycle and again in the WRITE cycle → MemWR=0 and all outputs 0 immediately; no write is seen by the memory model; next Start behaves normally.
- **Misaligned sh:** Addr=0x101, RegData=0xCAFE over 0x11223344.
  - With STORE_ALIGN_CHECK_EN: Misalign=1 and Done=1 at T+1, no MemWR.
  - Without it: writes 0x1122CAFE.

Source files
------------

// File: rtl/store_merge_unit.sv
`timescale 1ns/1ps
// Store path for sw/sh/sb: word stores write directly, sub-word stores read-modify-write the word.
// Optional macro STORE_ALIGN_CHECK_EN rejects misaligned sh/sw with a one-cycle Misalign pulse.

module store_merge_lane (
    input  logic       be,
    input  logic [7:0] old_byte,
    input  logic [7:0] new_byte,
    output logic [7:0] merged_byte
);
    assign merged_byte = be ? new_byte : old_byte;
endmodule

module store_merge_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  StoreType,
    input  logic [31:0] Addr,
    input  logic [31:0] RegData,
    input  logic [31:0] MemDataOut,
    output logic [31:0] MemAddr,
    output logic        MemWR,
    output logic [31:0] MemDataIn,
    output logic        Busy,
    output logic        Done,
    output logic        Misalign
);
    localparam int NUM_LANES = 4;
    localparam int CW        = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] T_SH = 2'b01;
    localparam logic [1:0] T_SB = 2'b10;

    typedef struct packed {
        logic [1:0]  stype;
        logic [1:0]  lane;
        logic [31:0] data;
    } req_t;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    req_t          req;

    logic [NUM_LANES-1:0]      be;
    logic [NUM_LANES-1:0][7:0] src;
    logic [NUM_LANES-1:0][7:0] old_w;
    logic [NUM_LANES-1:0][7:0] merged;
    logic                      sub_word;
    logic                      misalign_req;

    // Replicate the store source across lanes so each lane only picks its own byte.
    always_comb begin
        be  = '1;
        src = req.data;
        case (req.stype)
            T_SB: begin
                be  = 4'b0001 << req.lane;
                src = {4{req.data[7:0]}};
            end
            T_SH: begin
                be  = req.lane[1] ? 4'b1100 : 4'b0011;
                src = {2{req.data[15:0]}};
            end
            default: ;
        endcase
    end

    assign old_w = MemDataOut;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            store_merge_lane u_lane (
                .be          (be[i]),
                .old_byte    (old_w[i]),
                .new_byte    (src[i]),
                .merged_byte (merged[i])
            );
        end
    endgenerate

    assign sub_word = (StoreType == T_SH) || (StoreType == T_SB);

`ifdef STORE_ALIGN_CHECK_EN
    // Reserved type behaves as sw, so it needs a word-aligned address too.
    assign misalign_req = (StoreType == T_SH) ? Addr[0] :
                          (StoreType == T_SB) ? 1'b0 : (Addr[1:0] != 2'b00);
`else
    assign misalign_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req       <= '0;
            MemAddr   <= '0;
            MemWR     <= 1'b0;
            MemDataIn <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Misalign  <= 1'b0;
        end else begin
            MemWR    <= 1'b0;
            Done     <= 1'b0;
            Misalign <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (misalign_req) begin
                            Done     <= 1'b1;
                            Misalign <= 1'b1;
                        end else begin
                            req     <= '{stype: StoreType, lane: Addr[1:0], data: RegData};
                            MemAddr <= {Addr[31:2], 2'b00};
                            Busy    <= 1'b1;
                            if (sub_word) begin
                                state <= S_READ;
                                cnt   <= CW'(RD_LAT - 1);
                            end else begin
                                state     <= S_WRITE;
                                MemWR     <= 1'b1;
                                MemDataIn <= RegData;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        state     <= S_WRITE;
                        MemWR     <= 1'b1;
                        MemDataIn <= merged;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WRITE: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
